pipe_queue: RTL and testbench
=============================

PIPE_QUEUE -- requirements
Module: pipe_queue

Interface
REQ-001 SHALL have parameter WIDTH, default 64, meaning payload bits per entry (instruction/data word between two pipeline stages).
REQ-002 SHALL have parameter DEPTH, default 4, meaning entry count; legal values are powers of two, 2..32.
REQ-003 SHALL have port i_clk  input  1  meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port i_rst_n  input  1  meaning asynchronous active-low reset.
REQ-005 SHALL have port i_flush  input  1  meaning pipeline flush from writeback; discards all contents.
REQ-006 SHALL have port i_valid  input  1  meaning upstream presents an entry.
REQ-007 SHALL have port i_data  input  WIDTH  meaning upstream payload.
REQ-008 SHALL have port o_stall  output  1  meaning backpressure to upstream; entry not accepted.
REQ-009 SHALL have port o_valid  output  1  meaning head entry presented downstream.
REQ-010 SHALL have port o_data  output  WIDTH  meaning head payload.
REQ-011 SHALL have port i_stall  input  1  meaning downstream cannot accept the head this cycle.
REQ-012 SHALL have port o_count  output  $clog2(DEPTH+1)  meaning stored entries.

Function
REQ-013 SHALL enqueue when i_valid && !o_stall && !i_flush, writing i_data at the tail pointer.
REQ-014 SHALL dequeue when o_valid && !i_stall && !i_flush, advancing the head pointer.
REQ-015 SHALL drive o_stall = (count == DEPTH), registered state only; no combinational path from i_stall to o_stall.
REQ-016 SHALL therefore refuse enqueue when full even if a dequeue occurs in the same cycle.
REQ-017 SHALL, on simultaneous enqueue and dequeue when not full, leave count unchanged and advance both pointers.
REQ-018 SHALL wrap head and tail pointers from DEPTH-1 to 0.
REQ-019 SHALL keep count within 0..DEPTH; count+1 on enqueue only, count-1 on dequeue only.
REQ-020 SHALL present entries in strict FIFO order with o_data stable while o_valid && i_stall.
REQ-021 SHALL, while i_flush is high, force o_valid=0, block enqueue and dequeue, and clear count and both pointers at the clock edge.
REQ-022 SHALL give i_flush priority over every simultaneous enqueue or dequeue.
REQ-023 SHALL, without bypass, give a latency of one cycle from enqueue to o_valid.

Reset
REQ-024 SHALL, on i_rst_n low, immediately clear count, head and tail to 0, giving o_valid=0, o_stall=0, o_count=0, independent of i_clk.
REQ-025 SHALL not reset the storage array; o_data is don't-care while o_valid=0.
REQ-026 SHALL discard any in-flight operation when reset asserts mid-transfer and resume empty on the first edge after release.

Configuration
REQ-027 SHALL support macro PIPE_QUEUE_BYPASS_EN.
REQ-028 SHALL, with PIPE_QUEUE_BYPASS_EN defined, present i_data on o_data with o_valid=1 in the same cycle when count==0 && i_valid && !i_flush; if !i_stall the entry is consumed and not stored, otherwise it is stored.
REQ-029 SHALL, without PIPE_QUEUE_BYPASS_EN, drive o_valid = (count != 0) && !i_flush and o_data from the head entry only.

Structure
REQ-030 SHALL place the DEPTH legality limits and the default WIDTH/DEPTH constants in the shared config package; the payload type stays a parameter.
REQ-031 SHALL isolate storage in one sub-module pipe_queue_ram: DEPTH x WIDTH, one write port, one asynchronous read port, no reset.

Verification (WIDTH=32, DEPTH=4)
REQ-032 SHALL cover this scenario: push 0x11,0x22,0x33,0x44 with i_stall=1. Required response: o_stall=1 after the 4th edge, o_count=4; a 5th push of 0x55 is dropped.
REQ-033 SHALL cover this scenario: full queue, release i_stall for 4 cycles. Required response: o_data sequence 0x11,0x22,0x33,0x44; o_stall drops the cycle after the first pop; o_count ends at 0.
REQ-034 SHALL cover this scenario: count=2, push and pop simultaneously for 6 cycles with a data counter. Required response: o_count stays 2, order preserved across pointer wrap.
REQ-035 SHALL cover this scenario: count=3 with i_flush and i_valid asserted together. Required response: o_valid=0 that cycle; o_count=0, o_stall=0 next cycle; the flushed-cycle input is never output.
REQ-036 SHALL cover this scenario: empty queue, i_valid with 0xAB, i_stall=0. Required response: with BYPASS_EN, o_valid=1 and o_data=0xAB the same cycle and o_count stays 0; without it, o_valid=1 one cycle later.
REQ-037 SHALL cover this scenario: assert i_rst_n low between clock edges with count=3. Required response: o_valid=0 and o_count=0 immediately.

Source files
------------

// File: rtl/pipe_queue_pkg.sv
// Shared configuration for pipe_queue: default sizing and legal DEPTH range.
// No logic; constants and a legality helper only.
package pipe_queue_pkg;
  localparam int DEFAULT_WIDTH = 64;
  localparam int DEFAULT_DEPTH = 4;
  localparam int MIN_DEPTH     = 2;
  localparam int MAX_DEPTH     = 32;

  function automatic bit depth_ok(input int depth);
    return (depth >= MIN_DEPTH) && (depth <= MAX_DEPTH) && ((depth & (depth - 1)) == 0);
  endfunction
endpackage

// File: rtl/pipe_queue_ram.sv
// Entry storage for pipe_queue: DEPTH x WIDTH, one write port, async read, no reset.
// Latency: write visible on read port the cycle after the write edge.
// Backpressure: none; the caller qualifies i_we.
module pipe_queue_ram
  import pipe_queue_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = mem[i_raddr];

endmodule

// File: rtl/pipe_queue.sv
// Inter-stage pipeline queue with flush; same-cycle bypass when PIPE_QUEUE_BYPASS_EN is defined.
// Latency: one cycle enqueue to o_valid (zero with bypass on an empty queue).
// Backpressure: o_stall is purely registered (count == DEPTH); a same-cycle pop never frees a full slot.
module pipe_queue
  import pipe_queue_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_flush,
  input  logic                       i_valid,
  input  logic [WIDTH-1:0]           i_data,
  output logic                       o_stall,
  output logic                       o_valid,
  output logic [WIDTH-1:0]           o_data,
  input  logic                       i_stall,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  if (!depth_ok(DEPTH)) begin : g_bad_depth
    $error("pipe_queue: DEPTH must be a power of two in the legal range");
  end

  logic [CW-1:0]    count;
  logic [AW-1:0]    head;
  logic [AW-1:0]    tail;
  logic [WIDTH-1:0] head_data;
  logic             full;
  logic             empty;
  logic             enq;
  logic             deq;
  logic             wr_en;
  logic             rd_en;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign o_stall = full;
  assign o_count = count;

  assign enq = i_valid && !full && !i_flush;
  assign deq = o_valid && !i_stall && !i_flush;

`ifdef PIPE_QUEUE_BYPASS_EN
  // On an empty queue the input is shown directly; it is only stored if downstream stalls.
  assign o_valid = (!empty || i_valid) && !i_flush;
  assign o_data  = empty ? i_data : head_data;
  assign wr_en   = enq && !(empty && deq);
  assign rd_en   = deq && !empty;
`else
  assign o_valid = !empty && !i_flush;
  assign o_data  = head_data;
  assign wr_en   = enq;
  assign rd_en   = deq;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count <= '0;
      head  <= '0;
      tail  <= '0;
    end else if (i_flush) begin
      count <= '0;
      head  <= '0;
      tail  <= '0;
    end else begin
      // DEPTH is a power of two, so pointers wrap by natural overflow.
      if (wr_en) tail <= tail + 1'b1;
      if (rd_en) head <= head + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  pipe_queue_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .i_clk   (i_clk),
    .i_we    (wr_en),
    .i_waddr (tail),
    .i_wdata (i_data),
    .i_raddr (head),
    .o_rdata (head_data)
  );

endmodule

// File: tb/tb_pipe_queue.sv
// Bench for pipe_queue (WIDTH=32, DEPTH=4): queue-based reference model plus directed scenarios.
module tb_pipe_queue;
  localparam int W = 32;
  localparam int D = 4;

  logic         clk;
  logic         rst_n;
  logic         flush;
  logic         valid;
  logic [W-1:0] data;
  logic         stall_in;
  logic         o_stall;
  logic         o_valid;
  logic [W-1:0] o_data;
  logic [2:0]   o_count;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] q[$];

  pipe_queue #(.WIDTH(W), .DEPTH(D)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_flush (flush),
    .i_valid (valid),
    .i_data  (data),
    .o_stall (o_stall),
    .o_valid (o_valid),
    .o_data  (o_data),
    .i_stall (stall_in),
    .o_count (o_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: a plain queue updated from the FIFO rules at each edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
    end else if (flush) begin
      q.delete();
    end else begin
      bit can_push;
      bit bypass_take;
      can_push    = valid && (q.size() < D);
`ifdef PIPE_QUEUE_BYPASS_EN
      bypass_take = (q.size() == 0) && valid && !stall_in;
`else
      bypass_take = 1'b0;
`endif
      if (!bypass_take) begin
        if (q.size() > 0 && !stall_in) void'(q.pop_front());
        if (can_push) q.push_back(data);
      end
    end
  end

  // Per-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      logic         exp_valid;
      logic [W-1:0] exp_data;
      exp_valid = 1'b0;
      exp_data  = '0;
      if (!flush) begin
        if (q.size() > 0) begin
          exp_valid = 1'b1;
          exp_data  = q[0];
        end else begin
`ifdef PIPE_QUEUE_BYPASS_EN
          exp_valid = valid;
          exp_data  = data;
`endif
        end
      end
      check("model_valid", {31'b0, o_valid}, {31'b0, exp_valid});
      check("model_stall", {31'b0, o_stall}, {31'b0, (q.size() == D)});
      check("model_count", {29'b0, o_count}, q.size());
      if (exp_valid) check("model_data", o_data, exp_data);
    end
  end

  initial begin
    clk = 0; rst_n = 0; flush = 0; valid = 0; data = '0; stall_in = 0;
    #1;
    check("rst_valid", {31'b0, o_valid}, 0);
    check("rst_stall", {31'b0, o_stall}, 0);
    check("rst_count", {29'b0, o_count}, 0);
    #12 rst_n = 1;
    tick();

    // Fill to full with downstream stalled, then try a fifth push.
    stall_in = 1; valid = 1;
    for (int i = 0; i < 4; i++) begin
      data = 32'h11 * (i + 1);
      tick();
    end
    check("full_stall", {31'b0, o_stall}, 1);
    check("full_count", {29'b0, o_count}, 4);
    data = 32'h55;
    tick();
    check("drop_count", {29'b0, o_count}, 4);
    valid = 0;

    // Drain in order.
    stall_in = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("drain_data", o_data, 32'h11 * (i + 1));
      check("drain_valid", {31'b0, o_valid}, 1);
      tick();
      if (i == 0) check("stall_drop", {31'b0, o_stall}, 0);
    end
    check("drain_count", {29'b0, o_count}, 0);

    // Steady push+pop at count 2 across pointer wrap.
    stall_in = 1; valid = 1;
    data = 32'h100; tick();
    data = 32'h101; tick();
    stall_in = 0;
    for (int k = 0; k < 6; k++) begin
      data = 32'h102 + k;
      #1;
      check("wrap_data", o_data, 32'h100 + k);
      tick();
      check("wrap_count", {29'b0, o_count}, 2);
    end

    // Flush with concurrent push at count 3.
    stall_in = 1; data = 32'h200; tick();
    check("pre_flush_count", {29'b0, o_count}, 3);
    flush = 1; data = 32'h2FF;
    #1;
    check("flush_valid", {31'b0, o_valid}, 0);
    tick();
    flush = 0; valid = 0;
    #1;
    check("post_flush_count", {29'b0, o_count}, 0);
    check("post_flush_stall", {31'b0, o_stall}, 0);
    check("post_flush_valid", {31'b0, o_valid}, 0);
    tick();

    // Single entry into an empty queue.
    stall_in = 0; valid = 1; data = 32'hAB;
    #1;
`ifdef PIPE_QUEUE_BYPASS_EN
    check("byp_valid", {31'b0, o_valid}, 1);
    check("byp_data", o_data, 32'hAB);
    tick();
    valid = 0;
    #1;
    check("byp_count", {29'b0, o_count}, 0);
    check("byp_after_valid", {31'b0, o_valid}, 0);
`else
    check("nobyp_valid0", {31'b0, o_valid}, 0);
    tick();
    valid = 0;
    #1;
    check("nobyp_valid1", {31'b0, o_valid}, 1);
    check("nobyp_data", o_data, 32'hAB);
    check("nobyp_count", {29'b0, o_count}, 1);
    tick();
    check("nobyp_empty", {29'b0, o_count}, 0);
`endif

    // Asynchronous reset between edges with three entries held.
    stall_in = 1; valid = 1;
    for (int i = 0; i < 3; i++) begin
      data = 32'h300 + i;
      tick();
    end
    valid = 0;
    check("pre_rst_count", {29'b0, o_count}, 3);
    #2 rst_n = 0;
    #1;
    check("arst_valid", {31'b0, o_valid}, 0);
    check("arst_count", {29'b0, o_count}, 0);
    check("arst_stall", {31'b0, o_stall}, 0);
    @(negedge clk);
    #2 rst_n = 1;
    tick();
    check("post_rst_count", {29'b0, o_count}, 0);

    // Randomized traffic with varying stall pressure.
    for (int n = 0; n < 2000; n++) begin
      int stall_pct;
      stall_pct = ((n / 200) % 4) * 30;
      valid    = ($urandom_range(0, 99) < 70);
      stall_in = ($urandom_range(0, 99) < stall_pct);
      flush    = ($urandom_range(0, 63) == 0);
      data     = $urandom;
      tick();
    end
    valid = 0; flush = 0; stall_in = 0;
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
